data_mem_responder: RTL

//  Memory-side responder for the processor data port: accepts load/store requests
//  (address = ALUResult, store data = WriteData) and returns ReadData with a

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Data-port handshake between the processor (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemBusy;
  logic        AddrErr;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemBusy, AddrErr
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemBusy, AddrErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: word RAM behind a request/ready handshake,
// with misaligned/out-of-range detection on the latched request address.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [IW-1:0] idx_s;
  logic          addr_err_s;
  logic          ram_we_s;

  assign idx_s      = addr_q[IW+1:2];
  // Any address bit above the word index, or a non-word offset, is an error.
  assign addr_err_s = (addr_q[1:0] != 2'b00) || ((addr_q >> (IW + 2)) != 32'd0);
  assign ram_we_s   = (state_q == S_RESP) && wr_q && !addr_err_s;

  // Next-state, request capture and output precompute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.MemReq) begin
          wr_d    = bus.MemWrite;
          addr_d  = bus.Addr;
          wdata_d = bus.WriteData;
          cnt_d   = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Busy tracks the FSM; the response lands one registered stage after RESP.
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_q == S_RESP);
    err_d   = (state_q == S_RESP) && addr_err_s;
    if ((state_q == S_RESP) && !wr_q && !addr_err_s) begin
      rdata_d = ram_q[idx_s];
    end else begin
      rdata_d = 32'd0;
    end
  end

  // FSM state, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Word RAM; stores commit on the RESP->IDLE edge so a following load sees them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        ram_q[i] <= 32'd0;
      end
    end else if (ram_we_s) begin
      ram_q[idx_s] <= wdata_q;
    end
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
  assign bus.AddrErr  = err_q;

endmodule
